// File: rtl/uart_seq_pkg.sv
// ============================================================================
// Module      : uart_seq_pkg
// Description : Shared types and constants for the UART inference sequencer:
//               state encoding, error/out-of-range tx bytes and the helper
//               that maps a class index to its transmitted character.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CHECK   = 3'd2,
    START   = 3'd3,
    WAIT    = 3'd4,
    TX_REQ  = 3'd5,
    TX_WAIT = 3'd6
  } seq_state_t;

  localparam logic [7:0] ERR_BYTE        = 8'hEE;
  localparam logic [7:0] BAD_RESULT_BYTE = 8'h3F;

  // Class indices 0..9 become printable digits; anything larger is flagged
  function automatic logic [7:0] result_to_byte(input logic [3:0] result,
                                                input logic [7:0] base);
    return (result > 4'd9) ? BAD_RESULT_BYTE : (base + {4'd0, result});
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_strobe_sync.sv
// ============================================================================
// Module      : rx_strobe_sync
// Description : Two-flop synchronizer for an asynchronous level, plus a
//               one-cycle strobe on the rising edge of the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/uart_infer_sequencer.sv
// ============================================================================
// Module      : uart_infer_sequencer
// Description : Parses a UART frame (sync byte + pixels) into the image
//               buffer, runs one accelerator inference and transmits the
//               class as an ASCII byte.
//               Optional macro UART_SEQ_CHECKSUM_EN: adds an XOR checksum
//               byte after the pixels, checked before the accelerator starts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_infer_sequencer
  import uart_seq_pkg::*;
#(
  parameter int          N_PIXELS    = 784,
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  RESULT_BASE = 8'h30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic [3:0]        acc_result,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] c_LAST_PIX = ADDR_W'(N_PIXELS - 1);

  logic w_rx_strobe;
  logic w_rx_level_unused;
  logic w_tx_busy;
  logic w_tx_busy_rise_unused;

  rx_strobe_sync u_rx_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (rx_rdy),
    .o_level (w_rx_level_unused),
    .o_rise  (w_rx_strobe)
  );

  rx_strobe_sync u_tx_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (tx_busy),
    .o_level (w_tx_busy),
    .o_rise  (w_tx_busy_rise_unused)
  );

  seq_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic              r_pix_we, w_pix_we_nxt;
  logic [ADDR_W-1:0] r_pix_addr, w_pix_addr_nxt;
  logic [7:0]        r_pix_data, w_pix_data_nxt;
`ifdef UART_SEQ_CHECKSUM_EN
  logic [7:0]        r_xor, w_xor_nxt;
`endif

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_overrun  <= 1'b0;
      r_pix_we   <= 1'b0;
      r_pix_addr <= '0;
      r_pix_data <= 8'h00;
`ifdef UART_SEQ_CHECKSUM_EN
      r_xor      <= 8'h00;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_overrun  <= w_overrun_nxt;
      r_pix_we   <= w_pix_we_nxt;
      r_pix_addr <= w_pix_addr_nxt;
      r_pix_data <= w_pix_data_nxt;
`ifdef UART_SEQ_CHECKSUM_EN
      r_xor      <= w_xor_nxt;
`endif
    end
  end

  // Next-state and datapath update for the frame/inference sequence
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_overrun_nxt  = r_overrun;
    w_pix_we_nxt   = 1'b0;
    w_pix_addr_nxt = r_pix_addr;
    w_pix_data_nxt = r_pix_data;
`ifdef UART_SEQ_CHECKSUM_EN
    w_xor_nxt      = r_xor;
`endif
    case (r_state)
      IDLE: begin
        if (w_rx_strobe && (rx_data == SYNC_BYTE)) begin
          w_state_nxt   = LOAD;
          w_cnt_nxt     = '0;
          w_overrun_nxt = 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
          w_xor_nxt     = 8'h00;
`endif
        end
      end
      LOAD: begin
        // Sync byte values are plain pixel data here; no resync mid-frame
        if (w_rx_strobe) begin
          w_pix_we_nxt   = 1'b1;
          w_pix_addr_nxt = r_cnt;
          w_pix_data_nxt = rx_data;
          w_cnt_nxt      = r_cnt + 1'b1;
`ifdef UART_SEQ_CHECKSUM_EN
          w_xor_nxt      = r_xor ^ rx_data;
          if (r_cnt == c_LAST_PIX) w_state_nxt = CHECK;
`else
          if (r_cnt == c_LAST_PIX) w_state_nxt = START;
`endif
        end
      end
      CHECK: begin
`ifdef UART_SEQ_CHECKSUM_EN
        if (w_rx_strobe) begin
          if (rx_data == r_xor) begin
            w_state_nxt = START;
          end else begin
            w_tx_data_nxt = ERR_BYTE;
            w_state_nxt   = TX_REQ;
          end
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      START:   w_state_nxt = WAIT;
      WAIT: begin
        if (acc_done) begin
          w_tx_data_nxt = result_to_byte(acc_result, RESULT_BASE);
          w_state_nxt   = TX_REQ;
        end
      end
      TX_REQ:  if (w_tx_busy)  w_state_nxt = TX_WAIT;
      TX_WAIT: if (!w_tx_busy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Bytes arriving while the sequencer is not accepting are dropped
    if (w_rx_strobe && ((r_state == START) || (r_state == WAIT) ||
                        (r_state == TX_REQ) || (r_state == TX_WAIT))) begin
      w_overrun_nxt = 1'b1;
    end
  end

  assign tx_en     = (r_state == TX_REQ);
  assign tx_data   = r_tx_data;
  assign pix_we    = r_pix_we;
  assign pix_addr  = r_pix_addr;
  assign pix_data  = r_pix_data;
  assign acc_start = (r_state == START);
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;

endmodule

`default_nettype wire
